// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states,
// trap cause codes and next-PC source selection.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      RESET_HOLD,
      FETCH_REQ,
      FETCH_WAIT,
      EXECUTE,
      UPDATE
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_EXT      = 2'd0,
      CAUSE_MISALIGN = 2'd1,
      CAUSE_TIMEOUT  = 2'd2
   } cause_t;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BRANCH,
      SRC_JUMP,
      SRC_MRET,
      SRC_TRAP,
      SRC_TIMEOUT
   } src_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between control unit, instruction memory port and PC register.
// slave: sequencer side; master: environment (datapath/memory/PC) side.
interface pc_sequencer_if #(
   parameter int RETIRE_WIDTH = 32
);
   logic        [31:0] pc;
   logic               halt;
   logic               imem_ready;
   logic               exec_done;
   logic               branch_taken;
   logic        [31:0] branch_target;
   logic               jump;
   logic        [31:0] jump_target;
   logic               trap;
   logic               mret;
   logic        [31:0] mepc;
   logic               imem_request;
   logic               ir_load;
   logic               pc_write_enable;
   logic        [31:0] next_pc;
   logic               trap_taken;
   logic        [1:0]  trap_cause;
   logic [RETIRE_WIDTH-1:0] retired_count;

   modport slave (
      input  pc, halt, imem_ready, exec_done,
      input  branch_taken, branch_target,
      input  jump, jump_target, trap, mret, mepc,
      output imem_request, ir_load, pc_write_enable,
      output next_pc, trap_taken, trap_cause, retired_count
   );

   modport master (
      output pc, halt, imem_ready, exec_done,
      output branch_taken, branch_target,
      output jump, jump_target, trap, mret, mepc,
      input  imem_request, ir_load, pc_write_enable,
      input  next_pc, trap_taken, trap_cause, retired_count
   );
endinterface

// File: rtl/pc_sequencer_next_select.sv
// Next-PC priority mux with target alignment check.
// Ports: redirect requests and targets in; target, cause, is_trap out.
module pc_next_select
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
   input  logic        timeout,
   input  logic        trap,
   input  logic        mret,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [31:0] pc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] mepc,
   output logic [31:0] target,
   output cause_t      cause,
   output logic        is_trap
);

   src_t        src;
   logic [31:0] raw;

   always_comb begin
      src = SRC_SEQ;
      if (timeout)           src = SRC_TIMEOUT;
      else if (trap)         src = SRC_TRAP;
      else if (mret)         src = SRC_MRET;
      else if (jump)         src = SRC_JUMP;
      else if (branch_taken) src = SRC_BRANCH;
   end

   always_comb begin
      raw = pc + 32'd4;
      case (src)
         SRC_BRANCH: raw = branch_target;
         SRC_JUMP:   raw = jump_target;
         SRC_MRET:   raw = mepc;
         default:    raw = pc + 32'd4;
      endcase
   end

   // Sequential pc+4 is aligned by construction and wraps freely.
   always_comb begin
      target  = raw;
      cause   = CAUSE_EXT;
      is_trap = 1'b0;
      if (src == SRC_TIMEOUT) begin
         target  = TRAP_VECTOR;
         cause   = CAUSE_TIMEOUT;
         is_trap = 1'b1;
      end else if (src == SRC_TRAP) begin
         target  = TRAP_VECTOR;
         is_trap = 1'b1;
      end else if (src != SRC_SEQ && raw[1:0] != 2'b00) begin
         target  = TRAP_VECTOR;
         cause   = CAUSE_MISALIGN;
         is_trap = 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/update controller owning PC write_enable and next_pc.
// Ports: clock, reset (async, active-high), bus (pc_sequencer_if.slave).
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] INITIAL_PC    = 32'h0040_0000,
   parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0010,
   parameter int          FETCH_TIMEOUT = 255,
   parameter int          RETIRE_WIDTH  = 32
) (
   input  logic           clock,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   state_t                  state;
   state_t                  state_next;
   logic [7:0]              wait_count;
   logic                    timeout;
   logic                    imem_request;
   logic                    ir_load;
   logic                    pc_write_enable;
   logic [31:0]             next_pc;
   logic                    trap_taken;
   logic [1:0]              trap_cause;
   logic [RETIRE_WIDTH-1:0] retired_count;
   logic [31:0]             sel_target;
   cause_t                  sel_cause;
   logic                    sel_is_trap;

   // A ready arriving on the last allowed wait cycle still counts.
   assign timeout = (state == FETCH_WAIT) && !bus.imem_ready
                 && (wait_count == 8'(FETCH_TIMEOUT - 1));

   pc_next_select #(
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_select (
      .timeout       (timeout),
      .trap          (bus.trap),
      .mret          (bus.mret),
      .jump          (bus.jump),
      .branch_taken  (bus.branch_taken),
      .pc            (bus.pc),
      .branch_target (bus.branch_target),
      .jump_target   (bus.jump_target),
      .mepc          (bus.mepc),
      .target        (sel_target),
      .cause         (sel_cause),
      .is_trap       (sel_is_trap)
   );

   // The ir_load cycle is the instruction's first EXECUTE cycle;
   // exec_done is only honoured after it.
   always_comb begin
      state_next = state;
      case (state)
         RESET_HOLD: state_next = FETCH_REQ;
         FETCH_REQ:  state_next = FETCH_WAIT;
         FETCH_WAIT: begin
            if (bus.imem_ready) state_next = EXECUTE;
            else if (timeout)   state_next = UPDATE;
         end
         EXECUTE: begin
            if (!ir_load && bus.exec_done && !bus.halt)
               state_next = UPDATE;
         end
         UPDATE:     state_next = FETCH_REQ;
         default:    state_next = RESET_HOLD;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= RESET_HOLD;
         wait_count      <= '0;
         imem_request    <= 1'b0;
         ir_load         <= 1'b0;
         pc_write_enable <= 1'b0;
         next_pc         <= INITIAL_PC;
         trap_taken      <= 1'b0;
         trap_cause      <= 2'd0;
         retired_count   <= '0;
      end else begin
         state           <= state_next;
         wait_count      <= (state == FETCH_WAIT) ? wait_count + 8'd1 : 8'd0;
         imem_request    <= (state_next == FETCH_REQ);
         ir_load         <= (state == FETCH_WAIT) && (state_next == EXECUTE);
         pc_write_enable <= (state_next == UPDATE);
         trap_taken      <= (state_next == UPDATE) && sel_is_trap;
         if (state_next == UPDATE) begin
            next_pc    <= sel_target;
            trap_cause <= sel_is_trap ? sel_cause : CAUSE_EXT;
            if (!sel_is_trap)
               retired_count <= retired_count + RETIRE_WIDTH'(1);
         end
      end
   end

   assign bus.imem_request    = imem_request;
   assign bus.ir_load         = ir_load;
   assign bus.pc_write_enable = pc_write_enable;
   assign bus.next_pc         = next_pc;
   assign bus.trap_taken      = trap_taken;
   assign bus.trap_cause      = trap_cause;
   assign bus.retired_count   = retired_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Drives the interface on falling edges and checks outputs there.
module tb_pc_sequencer;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   pc_sequencer_if #(.RETIRE_WIDTH(32)) bus ();

   pc_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.halt          = 1'b0;
      bus.imem_ready    = 1'b0;
      bus.exec_done     = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'h0;
      bus.trap          = 1'b0;
      bus.mret          = 1'b0;
      bus.mepc          = 32'h0;
   endtask

   task automatic wait_request(input string tag);
      int n;
      n = 0;
      while (!bus.imem_request && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_req"}, 32'(bus.imem_request), 32'd1);
   endtask

   // One instruction: ready after gap wait cycles, exec_done one
   // cycle after ir_load; redirect inputs are set by the caller.
   task automatic run_instr(input string tag, input int gap,
                            input logic [31:0] exp_pc,
                            input logic exp_trap,
                            input logic [1:0] exp_cause,
                            input logic [31:0] exp_ret);
      wait_request(tag);
      for (int i = 0; i <= gap; i++) begin
         @(negedge clock);
         bus.imem_ready = (i == gap);
      end
      @(negedge clock);
      bus.imem_ready = 1'b0;
      chk({tag, "_irld"}, 32'(bus.ir_load), 32'd1);
      @(negedge clock);
      bus.exec_done = 1'b1;
      @(negedge clock);
      bus.exec_done = 1'b0;
      chk({tag, "_we"}, 32'(bus.pc_write_enable), 32'd1);
      chk({tag, "_npc"}, bus.next_pc, exp_pc);
      chk({tag, "_tt"}, 32'(bus.trap_taken), 32'(exp_trap));
      if (exp_trap)
         chk({tag, "_cause"}, 32'(bus.trap_cause), 32'(exp_cause));
      chk({tag, "_ret"}, bus.retired_count, exp_ret);
      clear_inputs();
      @(negedge clock);
      chk({tag, "_we_off"}, 32'(bus.pc_write_enable), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      checks = 0;
      errors = 0;
      clear_inputs();
      bus.pc = 32'h0040_0000;
      reset  = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_req", 32'(bus.imem_request), 32'd0);
      chk("rst_irld", 32'(bus.ir_load), 32'd0);
      chk("rst_we", 32'(bus.pc_write_enable), 32'd0);
      chk("rst_npc", bus.next_pc, 32'h0040_0000);
      chk("rst_tt", 32'(bus.trap_taken), 32'd0);
      chk("rst_cause", 32'(bus.trap_cause), 32'd0);
      chk("rst_ret", bus.retired_count, 32'd0);
      reset = 1'b0;

      // sequential fetch
      run_instr("seq", 1, 32'h0040_0004, 1'b0, 2'd0, 32'd1);

      bus.pc = 32'h0040_0004;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0040_0100;
      run_instr("br", 0, 32'h0040_0100, 1'b0, 2'd0, 32'd2);

      bus.pc = 32'h0040_0100;
      bus.jump = 1'b1;
      bus.jump_target = 32'h0040_0200;
      run_instr("jmp", 2, 32'h0040_0200, 1'b0, 2'd0, 32'd3);

      bus.pc = 32'h0040_0200;
      bus.trap = 1'b1;
      bus.jump = 1'b1;
      bus.jump_target = 32'h0040_0300;
      run_instr("trap", 0, 32'h0000_0010, 1'b1, 2'd0, 32'd3);

      bus.pc = 32'h0000_0010;
      bus.mret = 1'b1;
      bus.mepc = 32'h0040_0008;
      run_instr("mret", 0, 32'h0040_0008, 1'b0, 2'd0, 32'd4);

      bus.pc = 32'h0040_0008;
      bus.jump = 1'b1;
      bus.jump_target = 32'h0040_0102;
      run_instr("misal", 0, 32'h0000_0010, 1'b1, 2'd1, 32'd4);

      bus.pc = 32'hFFFF_FFFC;
      run_instr("wrap", 0, 32'h0000_0000, 1'b0, 2'd0, 32'd5);

      bus.pc = 32'h0000_0000;
      bus.mret = 1'b1;
      bus.mepc = 32'h0040_0020;
      bus.jump = 1'b1;
      bus.jump_target = 32'h0040_0300;
      run_instr("mret_pri", 0, 32'h0040_0020, 1'b0, 2'd0, 32'd6);

      bus.pc = 32'h0040_0020;
      bus.jump = 1'b1;
      bus.jump_target = 32'h0040_0040;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0040_0080;
      run_instr("jmp_pri", 0, 32'h0040_0040, 1'b0, 2'd0, 32'd7);

      // fetch timeout: 255 FETCH_WAIT cycles, UPDATE on the 256th edge
      wait_request("tmo");
      n = 0;
      while (!bus.pc_write_enable && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd256);
      chk("tmo_npc", bus.next_pc, 32'h0000_0010);
      chk("tmo_tt", 32'(bus.trap_taken), 32'd1);
      chk("tmo_cause", 32'(bus.trap_cause), 32'd2);
      chk("tmo_ret", bus.retired_count, 32'd7);
      @(negedge clock);

      // halt holds EXECUTE despite exec_done
      bus.pc = 32'h0000_0010;
      wait_request("halt");
      @(negedge clock);
      bus.imem_ready = 1'b1;
      @(negedge clock);
      bus.imem_ready = 1'b0;
      bus.halt = 1'b1;
      bus.exec_done = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.pc_write_enable) seen++;
      end
      chk("halt_we", 32'(seen), 32'd0);
      bus.halt = 1'b0;
      @(negedge clock);
      bus.exec_done = 1'b0;
      chk("halt_rel_we", 32'(bus.pc_write_enable), 32'd1);
      chk("halt_rel_npc", bus.next_pc, 32'h0000_0014);
      chk("halt_rel_ret", bus.retired_count, 32'd8);

      // reset in FETCH_WAIT aborts at once
      @(negedge clock);
      wait_request("arst");
      @(negedge clock);
      bus.imem_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk("arst_req", 32'(bus.imem_request), 32'd0);
      chk("arst_we", 32'(bus.pc_write_enable), 32'd0);
      chk("arst_npc", bus.next_pc, 32'h0040_0000);
      chk("arst_ret", bus.retired_count, 32'd0);
      @(negedge clock);
      bus.imem_ready = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("arst_refetch", 32'(bus.imem_request), 32'd1);
      @(negedge clock);
      chk("arst_no_irld", 32'(bus.ir_load), 32'd0);
      bus.pc = 32'h0040_0000;
      run_instr("post", 0, 32'h0040_0004, 1'b0, 2'd0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
